alu_cmd_seq: RTL

Command-side initiator for the ALU datapath: accepts operand/opcode commands over a valid/ready handshake, drives the combinational ALU inputs, waits a fixed settle time, then captures result and flags into a response held until accepted. It also has a sweep mode that steps the opcode from a start value to the maximum with fixed operands. It sits between the control logic or host interface and the ALU instance, replacing free-running stimulus with a handshaked, clocked front end.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_settle_timer.sv | 40 ++++
 rtl/alu_cmd_seq.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the ALU command sequencer.
//
// Holds the default datapath widths, the bit positions of the ALU flag
// vector {C,Z,P,V}, the sequencer FSM state encoding and the width of the
// settle counter. Imported by alu_settle_timer and alu_cmd_seq.
package alu_pkg;

    // Default widths for the operand/result bus and the opcode field.
    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_OPCODE_WIDTH = 4;

    // Bit positions inside the 4-bit flag vector {C,Z,P,V}.
    localparam int FLAG_C = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_P = 1;
    localparam int FLAG_V = 0;

    // SETTLE_CYCLES is limited to 1..15, so a 4-bit counter holds SETTLE_CYCLES-1.
    localparam int SETTLE_W = 4;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,  // waiting for a command, cmd_ready high
        ST_SETTLE = 2'd1,  // ALU inputs held while the result settles
        ST_RESP   = 2'd2   // response presented, waiting for rsp_ready
    } seq_state_t;

endpackage : alu_pkg

// File: rtl/alu_settle_timer.sv
// alu_settle_timer -- loadable down-counter timing the ALU settle window.
//
// Ports:
//   clk, rst_n  : clock and asynchronous active-low reset
//   load        : load load_value into the counter (has priority over en)
//   en          : count down by one per cycle while non-zero
//   load_value  : value loaded on load (SETTLE_CYCLES-1 from the sequencer)
//   done        : high while enabled and the count has reached zero
module alu_settle_timer
    import alu_pkg::*;
#(
    parameter int CNT_WIDTH = SETTLE_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 en,
    input  logic [CNT_WIDTH-1:0] load_value,
    output logic                 done
);

    logic [CNT_WIDTH-1:0] count_q;

    // NOTE: sequential state is written with non-blocking (<=) assignments so
    // every flop samples the pre-edge values of its sources.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (en && (count_q != '0)) begin
            count_q <= count_q - CNT_WIDTH'(1);
        end
    end

    // A load of zero makes done true on the very first enabled cycle, which
    // gives the one-cycle settle window for SETTLE_CYCLES=1.
    assign done = en && (count_q == '0);

endmodule : alu_settle_timer

// File: rtl/alu_cmd_seq.sv
// alu_cmd_seq -- handshaked command front end for a combinational ALU.
//
// Accepts {a, b, opcode, sweep} commands on a valid/ready channel, drives the
// registered ALU inputs, waits SETTLE_CYCLES, then captures result and flags
// into a response held until accepted. A sweep command steps the opcode from
// cmd_opcode up to the maximum opcode, one response per opcode, without wrap.
//
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   cmd_valid / cmd_ready            : command handshake (ready only in IDLE)
//   cmd_a, cmd_b, cmd_opcode         : operands and (start) opcode
//   cmd_sweep                        : 1 = sweep cmd_opcode..OP_MAX
//   alu_a, alu_b, alu_opcode         : registered ALU inputs
//   alu_result, alu_flags            : ALU outputs {C,Z,P,V}
//   rsp_valid / rsp_ready            : response handshake
//   rsp_result, rsp_flags            : captured ALU outputs
//   rsp_opcode                       : opcode the response belongs to
//   rsp_last                         : final response of the command
//   busy                             : sequencer not in IDLE
module alu_cmd_seq
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int OPCODE_WIDTH  = DEF_OPCODE_WIDTH,
    parameter int SETTLE_CYCLES = 1   // legal range 1..15
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [DATA_WIDTH-1:0]   cmd_a,
    input  logic [DATA_WIDTH-1:0]   cmd_b,
    input  logic [OPCODE_WIDTH-1:0] cmd_opcode,
    input  logic                    cmd_sweep,

    output logic [DATA_WIDTH-1:0]   alu_a,
    output logic [DATA_WIDTH-1:0]   alu_b,
    output logic [OPCODE_WIDTH-1:0] alu_opcode,
    input  logic [DATA_WIDTH-1:0]   alu_result,
    input  logic [3:0]              alu_flags,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_result,
    output logic [3:0]              rsp_flags,
    output logic [OPCODE_WIDTH-1:0] rsp_opcode,
    output logic                    rsp_last,

    output logic                    busy
);

    localparam logic [OPCODE_WIDTH-1:0] OP_MAX      = '1;
    localparam logic [SETTLE_W-1:0]     SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

    seq_state_t state_q, state_d;
    logic       sweep_q;
    logic       cmd_fire;
    logic       rsp_fire;
    logic       last_op;
    logic       step_next;
    logic       timer_load;
    logic       timer_en;
    logic       timer_done;

    // Both ready and busy are pure decodes of the state register.
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);

    assign cmd_fire  = cmd_valid && cmd_ready;
    assign rsp_fire  = rsp_valid && rsp_ready;

    // The response in flight is the last one when not sweeping, or when the
    // sweep has reached the top opcode; this is what stops the opcode wrapping.
    assign last_op   = !sweep_q || (alu_opcode == OP_MAX);

    // Accepted non-final sweep response: advance to the next opcode.
    assign step_next = (state_q == ST_RESP) && rsp_fire && !rsp_last;

    assign timer_load = cmd_fire || step_next;
    assign timer_en   = (state_q == ST_SETTLE);

    alu_settle_timer #(
        .CNT_WIDTH (SETTLE_W)
    ) u_settle_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load),
        .en         (timer_en),
        .load_value (SETTLE_LOAD),
        .done       (timer_done)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    // NOTE: state_d is given its hold value before the case so every path
    // assigns it and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (timer_done) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_fire) begin
                    state_d = rsp_last ? ST_IDLE : ST_SETTLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // ALU input registers and sweep flag
    // ------------------------------------------------------------------
    // These keep their last values in IDLE so the ALU output stays observable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            sweep_q    <= 1'b0;
        end else if (cmd_fire) begin
            alu_a      <= cmd_a;
            alu_b      <= cmd_b;
            alu_opcode <= cmd_opcode;
            sweep_q    <= cmd_sweep;
        end else if (step_next) begin
            alu_opcode <= alu_opcode + OPCODE_WIDTH'(1);
        end
    end

    // ------------------------------------------------------------------
    // Response registers
    // ------------------------------------------------------------------
    // Capture happens only on the SETTLE->RESP edge, so the payload is stable
    // for as long as the consumer applies backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_opcode <= '0;
            rsp_last   <= 1'b0;
        end else if ((state_q == ST_SETTLE) && timer_done) begin
            rsp_valid  <= 1'b1;
            rsp_result <= alu_result;
            rsp_flags  <= alu_flags;
            rsp_opcode <= alu_opcode;
            rsp_last   <= last_op;
        end else if ((state_q == ST_RESP) && rsp_fire) begin
            rsp_valid  <= 1'b0;
        end
    end

endmodule : alu_cmd_seq
